// File: rtl/ncs_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : ncs_input_conditioner_if
// Brief    : Sample in/out handshake bundle for the input conditioner.
// Revision : 1.0 - initial release
// ============================================================================
interface ncs_input_conditioner_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/ncs_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : ncs_input_conditioner
// Brief    : Input FIFO, 16-sample DC calibration, then DC removal with
//            slow tracking and saturating output.
// Revision : 1.0 - initial release
// ============================================================================
module ncs_input_conditioner #(
  parameter int DEPTH       = 4,
  parameter int TRACK_SHIFT = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  ncs_input_conditioner_if.slave  bus,
  output logic [1:0]              state,
  output logic                    sat_flag
);

  localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cw = $clog2(DEPTH + 1);
  localparam logic [c_cw-1:0] c_full    = c_cw'(DEPTH);
  localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);
  localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);

  localparam logic [1:0] c_idle  = 2'b00;
  localparam logic [1:0] c_calib = 2'b01;
  localparam logic [1:0] c_run   = 2'b10;

  logic [15:0]      r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_cw-1:0]  r_count;
  logic             r_live;
  logic [1:0]       r_state;
  logic [19:0]      r_acc;
  logic [3:0]       r_cal_cnt;
  logic [15:0]      r_dc;
  logic [15:0]      r_out_data;
  logic             r_out_valid;
  logic             r_sat;

  logic               w_in_ready;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [15:0]        w_sample;
  logic [19:0]        w_acc_next;
  logic signed [16:0] w_diff;
  logic signed [16:0] w_dc_next;
  logic               w_pos_ovf;
  logic               w_neg_ovf;
  logic [15:0]        w_sat_data;
  logic               w_unused;

  // r_live keeps in_ready low for the whole reset and releases it one edge later
  assign w_in_ready = r_live && (r_count < c_full);
  assign w_empty    = (r_count == '0);
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_sample   = r_mem[r_rd_ptr];

  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      c_calib: w_pop = !w_empty;
      c_run:   w_pop = !w_empty && (!r_out_valid || bus.out_ready);
      default: w_pop = 1'b0;
    endcase
  end

  assign w_acc_next = r_acc + {{4{w_sample[15]}}, w_sample};

  // Both the output and the tracking step use the pre-update dc
  assign w_diff    = $signed({w_sample[15], w_sample}) - $signed({r_dc[15], r_dc});
  assign w_dc_next = $signed({r_dc[15], r_dc}) + (w_diff >>> TRACK_SHIFT);

  assign w_pos_ovf  = !w_diff[16] &&  w_diff[15];
  assign w_neg_ovf  =  w_diff[16] && !w_diff[15];
  assign w_sat_data = w_pos_ovf ? 16'h7FFF :
                      w_neg_ovf ? 16'h8000 : w_diff[15:0];

  assign w_unused = ^{w_dc_next[16], w_acc_next[3:0]};

  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_live      <= 1'b0;
      r_state     <= c_idle;
      r_acc       <= '0;
      r_cal_cnt   <= '0;
      r_dc        <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_sat       <= 1'b0;
    end else begin
      r_live <= 1'b1;

      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase

      case (r_state)
        c_idle: begin
          if (!w_empty) r_state <= c_calib;
        end
        c_calib: begin
          if (w_pop) begin
            r_acc     <= w_acc_next;
            r_cal_cnt <= r_cal_cnt + 4'd1;
            if (r_cal_cnt == 4'd15) begin
              r_dc    <= w_acc_next[19:4];
              r_state <= c_run;
            end
          end
        end
        c_run: begin
          if (w_pop) begin
            r_out_data  <= w_sat_data;
            r_out_valid <= 1'b1;
            r_dc        <= w_dc_next[15:0];
            if (w_pos_ovf || w_neg_ovf) r_sat <= 1'b1;
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign state         = r_state;
  assign sat_flag      = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_ncs_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_ncs_input_conditioner
// Brief    : Directed + randomized bench with a queue/integer reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ncs_input_conditioner;
  localparam int DEPTH       = 4;
  localparam int TRACK_SHIFT = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] state;
  logic       sat_flag;

  ncs_input_conditioner_if bus ();

  ncs_input_conditioner #(.DEPTH(DEPTH), .TRACK_SHIFT(TRACK_SHIFT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .state    (state),
    .sat_flag (sat_flag)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int cap[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integers and a queue, stepped once per rising edge
  int q[$];
  int m_state = 0, m_acc = 0, m_ncal = 0, m_dc = 0;
  int m_od = 0, m_ov = 0, m_sat = 0, m_live = 0;

  function automatic int m_rdy();
    return (m_live != 0 && q.size() < DEPTH) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    int s, d;
    bit push;
    if (!rst) begin
      q.delete();
      m_state = 0; m_acc = 0; m_ncal = 0; m_dc = 0;
      m_od = 0; m_ov = 0; m_sat = 0; m_live = 0;
    end else begin
      push = bus.in_valid && (m_rdy() != 0);
      if (m_state == 0) begin
        if (q.size() > 0) m_state = 1;
      end else if (m_state == 1) begin
        if (q.size() > 0) begin
          s = q.pop_front();
          m_acc += s;
          m_ncal++;
          if (m_ncal == 16) begin
            m_dc = m_acc >>> 4;
            m_state = 2;
          end
        end
      end else begin
        if (q.size() > 0 && (m_ov == 0 || bus.out_ready)) begin
          s = q.pop_front();
          d = s - m_dc;
          if (d > 32767)       begin m_od = 32767;  m_sat = 1; end
          else if (d < -32768) begin m_od = -32768; m_sat = 1; end
          else                  m_od = d;
          m_dc = m_dc + (d >>> TRACK_SHIFT);
          m_ov = 1;
        end else if (bus.out_ready) begin
          m_ov = 0;
        end
      end
      if (push) q.push_back(int'($signed(bus.in_data)));
      m_live = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state",     int'(state),         m_state);
      chk("in_ready",  int'(bus.in_ready),  m_rdy());
      chk("out_valid", int'(bus.out_valid), m_ov);
      chk("out_data",  int'(bus.out_data),  m_od & 32'hFFFF);
      chk("sat_flag",  int'(sat_flag),      m_sat);
      if (bus.out_valid && bus.out_ready) cap.push_back(int'(bus.out_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    repeat (n) tick();
    rst = 1'b1;
  endtask

  task automatic send(input logic [15:0] v);
    bit took = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    for (int i = 0; i < 64 && !took; i++) begin
      took = bus.in_ready;
      tick();
    end
    chk("send_accept", int'(took), 1);
    bus.in_valid = 1'b0;
  endtask

  function automatic int cap_at(input int i);
    return (cap.size() > i) ? cap[i] : -1;
  endfunction

  initial begin
    int k;
    bit took;
    logic [15:0] bp_vals [6];

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b1;
    rst = 1'b0;

    // Reset held for two edges
    @(posedge clk); #1;
    chk_en = 1'b1;
    tick();
    chk("rst_state",     int'(state),         0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data",  int'(bus.out_data),  0);
    chk("rst_sat",       int'(sat_flag),      0);
    chk("rst_in_ready",  int'(bus.in_ready),  0);
    rst = 1'b1;
    tick();
    chk("rel_in_ready",  int'(bus.in_ready),  1);

    // Calibration at 0x0100 gives a zero first output
    cap.delete();
    repeat (16) send(16'h0100);
    repeat (4) tick();
    chk("calib_no_out", cap.size(), 0);
    chk("calib_state",  int'(state), 2);
    send(16'h0100);
    repeat (4) tick();
    chk("calib_n_out",  cap.size(), 1);
    chk("calib_first",  cap_at(0), 16'h0000);

    // DC tracking: dc moves 0 -> 0x0010 after the first 0x0400
    do_reset(2);
    cap.delete();
    repeat (16) send(16'h0000);
    send(16'h0400);
    send(16'h0400);
    repeat (4) tick();
    chk("track_n_out", cap.size(), 2);
    chk("track_out0",  cap_at(0), 16'h0400);
    chk("track_out1",  cap_at(1), 16'h03F0);

    // Positive saturation and sticky flag
    do_reset(2);
    cap.delete();
    repeat (16) send(16'h8000);
    send(16'h7FFF);
    repeat (3) tick();
    chk("sat_out",  cap_at(0), 16'h7FFF);
    chk("sat_flag", int'(sat_flag), 1);
    repeat (3) send(16'h0000);
    repeat (3) tick();
    chk("sat_sticky", int'(sat_flag), 1);

    // Backpressure: one output register plus DEPTH FIFO entries
    for (int i = 0; i < 6; i++) bp_vals[i] = 16'(16'h1000 + i * 16'h0111);
    bus.out_ready = 1'b0;
    cap.delete();
    k = 0;
    for (int c = 0; c < 12; c++) begin
      bus.in_valid = (k < 6);
      bus.in_data  = bp_vals[(k < 6) ? k : 5];
      took = bus.in_valid && bus.in_ready;
      tick();
      if (took) k++;
    end
    chk("bp_accepted", k, 5);
    chk("bp_in_ready", int'(bus.in_ready), 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (8) tick();
    chk("bp_n_out", cap.size(), 5);

    // Mid-run reset with data pending in FIFO and output register
    bus.out_ready = 1'b0;
    send(16'h2000);
    send(16'h2000);
    send(16'h2000);
    rst = 1'b0;
    tick();
    chk("mid_state",     int'(state),         0);
    chk("mid_out_valid", int'(bus.out_valid), 0);
    chk("mid_in_ready",  int'(bus.in_ready),  0);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    cap.delete();
    repeat (16) send(16'h0200);
    repeat (4) tick();
    chk("mid_no_out", cap.size(), 0);
    send(16'h0300);
    repeat (3) tick();
    chk("mid_n_out", cap.size(), 1);
    chk("mid_out0",  cap_at(0), 16'h0100);

    // Randomized traffic with one reset in the middle
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                  : 16'(16'h0800 + $urandom_range(0, 255));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      rst = (i != 1500);
      tick();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
